// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM interface between fetch, load/store and video ports.
// Holds the winner's transaction until the interface is ready or a watchdog aborts it.
module sram_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        i_clock,
    input  logic        i_reset_n,

    input  logic        i_p0_request,
    input  logic        i_p0_rw,
    input  logic [31:0] i_p0_address,
    input  logic [31:0] i_p0_wdata,
    output logic [31:0] o_p0_rdata,
    output logic        o_p0_ready,
    output logic        o_p0_timeout,

    input  logic        i_p1_request,
    input  logic        i_p1_rw,
    input  logic [31:0] i_p1_address,
    input  logic [31:0] i_p1_wdata,
    output logic [31:0] o_p1_rdata,
    output logic        o_p1_ready,
    output logic        o_p1_timeout,

    input  logic        i_p2_request,
    input  logic        i_p2_rw,
    input  logic [31:0] i_p2_address,
    input  logic [31:0] i_p2_wdata,
    output logic [31:0] o_p2_rdata,
    output logic        o_p2_ready,
    output logic        o_p2_timeout,

    output logic        o_request,
    output logic        o_rw,
    output logic [31:0] o_address,
    output logic [31:0] o_wdata,
    input  logic [31:0] i_rdata,
    input  logic        i_ready
);

    localparam int unsigned WdW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [1:0]      r_last;
    logic [1:0]      w_last_d;
    logic [1:0]      r_win;
    logic [1:0]      w_win_d;
    logic [WdW-1:0]  r_wd;
    logic [WdW-1:0]  w_wd_d;
    logic            r_request;
    logic            w_request_d;
    logic            r_rw;
    logic            w_rw_d;
    logic [31:0]     r_address;
    logic [31:0]     w_address_d;
    logic [31:0]     r_wdata;
    logic [31:0]     w_wdata_d;
    logic [31:0]     r_rdata [3];
    logic [31:0]     w_rdata_d [3];
    logic [2:0]      r_ready;
    logic [2:0]      w_ready_d;
    logic [2:0]      r_timeout;
    logic [2:0]      w_timeout_d;

    logic [2:0]      w_req;
    logic [1:0]      w_pick;
    logic            w_sel_rw;
    logic [31:0]     w_sel_address;
    logic [31:0]     w_sel_wdata;
    logic [2:0]      w_win_oh;

    assign w_req    = {i_p2_request, i_p1_request, i_p0_request};
    assign w_win_oh = 3'b001 << r_win;

    // First requester after the last winner, wrapping 2 -> 0.
    always_comb begin
        w_pick = 2'd0;
        case (r_last)
            2'd0: begin
                if (w_req[1])      w_pick = 2'd1;
                else if (w_req[2]) w_pick = 2'd2;
                else               w_pick = 2'd0;
            end
            2'd1: begin
                if (w_req[2])      w_pick = 2'd2;
                else if (w_req[0]) w_pick = 2'd0;
                else               w_pick = 2'd1;
            end
            default: begin
                if (w_req[0])      w_pick = 2'd0;
                else if (w_req[1]) w_pick = 2'd1;
                else               w_pick = 2'd2;
            end
        endcase
    end

    always_comb begin
        w_sel_rw      = i_p0_rw;
        w_sel_address = i_p0_address;
        w_sel_wdata   = i_p0_wdata;
        case (w_pick)
            2'd1: begin
                w_sel_rw      = i_p1_rw;
                w_sel_address = i_p1_address;
                w_sel_wdata   = i_p1_wdata;
            end
            2'd2: begin
                w_sel_rw      = i_p2_rw;
                w_sel_address = i_p2_address;
                w_sel_wdata   = i_p2_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_d   = r_state;
        w_last_d    = r_last;
        w_win_d     = r_win;
        w_wd_d      = r_wd;
        w_request_d = r_request;
        w_rw_d      = r_rw;
        w_address_d = r_address;
        w_wdata_d   = r_wdata;
        w_rdata_d   = r_rdata;
        w_ready_d   = 3'b000;
        w_timeout_d = 3'b000;

        case (r_state)
            StIdle: begin
                w_wd_d = '0;
                if (|w_req) begin
                    w_win_d     = w_pick;
                    w_last_d    = w_pick;
                    w_rw_d      = w_sel_rw;
                    w_address_d = w_sel_address;
                    w_wdata_d   = w_sel_wdata;
                    w_request_d = 1'b1;
                    w_state_d   = StGrant;
                end
            end
            StGrant: begin
                if (i_ready) begin
                    for (int i = 0; i < 3; i++) begin
                        if (w_win_oh[i] && !r_rw) begin
                            w_rdata_d[i] = i_rdata;
                        end
                    end
                    w_ready_d   = w_win_oh;
                    w_request_d = 1'b0;
                    w_wd_d      = '0;
                    w_state_d   = StRelease;
                end else if (r_wd == WdMax) begin
                    // Abort: complete the requester with a flagged pulse, rdata untouched.
                    w_ready_d   = w_win_oh;
                    w_timeout_d = w_win_oh;
                    w_request_d = 1'b0;
                    w_wd_d      = '0;
                    w_state_d   = StRelease;
                end else begin
                    w_wd_d = r_wd + 1'b1;
                end
            end
            StRelease: begin
                w_wd_d    = '0;
                w_state_d = StIdle;
            end
            default: begin
                w_request_d = 1'b0;
                w_state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= StIdle;
            r_last    <= 2'd2;
            r_win     <= 2'd0;
            r_wd      <= '0;
            r_request <= 1'b0;
            r_rw      <= 1'b0;
            r_address <= '0;
            r_wdata   <= '0;
            r_ready   <= 3'b000;
            r_timeout <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_rdata[i] <= '0;
            end
        end else begin
            r_state   <= w_state_d;
            r_last    <= w_last_d;
            r_win     <= w_win_d;
            r_wd      <= w_wd_d;
            r_request <= w_request_d;
            r_rw      <= w_rw_d;
            r_address <= w_address_d;
            r_wdata   <= w_wdata_d;
            r_ready   <= w_ready_d;
            r_timeout <= w_timeout_d;
            for (int i = 0; i < 3; i++) begin
                r_rdata[i] <= w_rdata_d[i];
            end
        end
    end

    assign o_request    = r_request;
    assign o_rw         = r_rw;
    assign o_address    = r_address;
    assign o_wdata      = r_wdata;

    assign o_p0_rdata   = r_rdata[0];
    assign o_p1_rdata   = r_rdata[1];
    assign o_p2_rdata   = r_rdata[2];
    assign o_p0_ready   = r_ready[0];
    assign o_p1_ready   = r_ready[1];
    assign o_p2_ready   = r_ready[2];
    assign o_p0_timeout = r_timeout[0];
    assign o_p1_timeout = r_timeout[1];
    assign o_p2_timeout = r_timeout[2];

endmodule
